// File: rtl/bsg_mux_one_hot_arb_buffered_pkg.sv
// Shared helpers for the buffered one-hot arbitrating mux.
// Pointer width, one-hot check and one-hot to binary encode.
package bsg_mux_one_hot_arb_buffered_pkg;

  localparam int max_els_lp = 32;

  // Width of a channel index; never narrower than one bit.
  function automatic int lg_els(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  function automatic logic one_hot_p(
    input logic [max_els_lp-1:0] v
  );
    int cnt;
    cnt = 0;
    for (int k = 0; k < max_els_lp; k++)
      cnt += int'(v[k]);
    return (cnt == 1);
  endfunction

  function automatic logic [4:0] oh_to_bin(
    input logic [max_els_lp-1:0] v
  );
    logic [4:0] idx;
    idx = '0;
    for (int k = 0; k < max_els_lp; k++)
      if (v[k]) idx |= 5'(k);
    return idx;
  endfunction

endpackage

// File: rtl/bsg_mux_one_hot_arb_buffered_arb.sv
// Round-robin one-hot arbiter, purely combinational.
// Searches upward from last_i+1, wrapping modulo els_p.
module bsg_arb_round_robin_one_hot #(
  parameter int els_p     = 2,
  parameter int lg_els_lp = 1
) (
  input  logic [els_p-1:0]     v_i,
  input  logic [lg_els_lp-1:0] last_i,
  output logic [els_p-1:0]     grant_o
);

  int   idx;
  logic found;

  // first requester after the last winner takes the grant
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= els_p; i++) begin
      idx = int'(last_i) + i;
      if (idx >= els_p) idx = idx - els_p;
      if (!found && v_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_mux_one_hot_arb_buffered.sv
// N-channel arbitrating mux with one registered output stage.
// Round-robin or forced one-hot select; sticky bad-select flag.
module bsg_mux_one_hot_arb_buffered
  import bsg_mux_one_hot_arb_buffered_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 2,
  localparam int lg_els_lp = lg_els(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p-1:0]         v_i,
  input  logic [els_p*width_p-1:0] data_i,
  output logic [els_p-1:0]         ready_o,
  input  logic                     force_i,
  input  logic [els_p-1:0]         sel_one_hot_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     ready_i,
  output logic [lg_els_lp-1:0]     chan_o,
  output logic                     err_o
);

  logic                 v_q, v_d;
  logic [width_p-1:0]   data_q, data_d;
  logic [lg_els_lp-1:0] chan_q, chan_d;
  logic [lg_els_lp-1:0] last_q, last_d;
  logic                 err_q, err_d;

  logic                 load_en;
  logic                 sel_ok;
  logic [els_p-1:0]     rr_grant;
  logic [els_p-1:0]     grant;
  logic [lg_els_lp-1:0] grant_idx;
  logic [width_p-1:0]   mux;

  assign load_en = ~v_q | ready_i;
  assign sel_ok  = one_hot_p(max_els_lp'(sel_one_hot_i));

  bsg_arb_round_robin_one_hot #(
    .els_p    (els_p),
    .lg_els_lp(lg_els_lp)
  ) u_arb (
    .v_i    (v_i),
    .last_i (last_q),
    .grant_o(rr_grant)
  );

  // forced select overrides the arbiter; a bad select grants nothing
  always_comb begin
    grant = rr_grant;
    if (force_i)
      grant = sel_ok ? (sel_one_hot_i & v_i) : '0;
  end

  // upstream never sees ready while reset is held
  assign ready_o = grant & {els_p{load_en & reset_n_i}};

  assign grant_idx =
    lg_els_lp'(oh_to_bin(max_els_lp'(grant)));

  // mask each channel by its grant bit and OR them together
  always_comb begin
    mux = '0;
    for (int k = 0; k < els_p; k++)
      mux |= data_i[k*width_p +: width_p]
           & {width_p{grant[k]}};
  end

  // next state: load when free or draining, else hold
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    chan_d = chan_q;
    last_d = last_q;
    err_d  = err_q | (force_i & ~sel_ok);
    if (load_en) begin
      v_d = |grant;
      if (|grant) begin
        data_d = mux;
        chan_d = grant_idx;
        last_d = grant_idx;
      end
    end
  end

  // output register stage and arbitration pointer
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      chan_q <= '0;
      last_q <= lg_els_lp'(els_p - 1);
      err_q  <= 1'b0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      chan_q <= chan_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
  assign chan_o = chan_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_bsg_mux_one_hot_arb_buffered.sv
// Bench for the buffered arbitrating mux: 2x32 and 4x8 instances.
// Directed scenarios plus random traffic against a queue-free model.
module tb_bsg_mux_one_hot_arb_buffered;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  v2, rdy2, sel2;
  logic [63:0] d2;
  logic        f2, ri2, vo2, err2;
  logic [31:0] do2;
  logic [0:0]  ch2;

  logic [3:0]  v4, rdy4, sel4;
  logic [31:0] d4;
  logic        f4, ri4, vo4, err4;
  logic [7:0]  do4;
  logic [1:0]  ch4;

  int errors = 0;
  int checks = 0;

  bsg_mux_one_hot_arb_buffered #(
    .width_p(32), .els_p(2)
  ) u_dut2 (
    .clk_i(clk), .reset_n_i(rst_n),
    .v_i(v2), .data_i(d2), .ready_o(rdy2),
    .force_i(f2), .sel_one_hot_i(sel2),
    .v_o(vo2), .data_o(do2), .ready_i(ri2),
    .chan_o(ch2), .err_o(err2)
  );

  bsg_mux_one_hot_arb_buffered #(
    .width_p(8), .els_p(4)
  ) u_dut4 (
    .clk_i(clk), .reset_n_i(rst_n),
    .v_i(v4), .data_i(d4), .ready_o(rdy4),
    .force_i(f4), .sel_one_hot_i(sel4),
    .v_o(vo4), .data_o(do4), .ready_i(ri4),
    .chan_o(ch4), .err_o(err4)
  );

  // behavioural state: what the output register should hold
  bit m2v, m2e, m4v, m4e;
  logic [31:0] m2d;
  logic [7:0]  m4d;
  int m2c, m2l, m4c, m4l;

  function automatic logic [31:0] grant_of(
    int n, logic [31:0] v, int last,
    logic fe, logic [31:0] sel);
    if (fe)
      return ($countones(sel) == 1) ? (sel & v) : 0;
    for (int i = 1; i <= n; i++) begin
      int k;
      k = (last + i) % n;
      if (v[k]) return 32'd1 << k;
    end
    return 0;
  endfunction

  function automatic int idx_of(logic [31:0] g);
    for (int k = 0; k < 32; k++)
      if (g[k]) return k;
    return 0;
  endfunction

  function automatic logic [1:0] exp_rdy2();
    logic [31:0] g;
    g = grant_of(2, 32'(v2), m2l, f2, 32'(sel2));
    if (!rst_n || (m2v && !ri2)) return 2'b00;
    return g[1:0];
  endfunction

  function automatic logic [3:0] exp_rdy4();
    logic [31:0] g;
    g = grant_of(4, 32'(v4), m4l, f4, 32'(sel4));
    if (!rst_n || (m4v && !ri4)) return 4'b0000;
    return g[3:0];
  endfunction

  task automatic mreset();
    m2v = 0; m2d = 0; m2c = 0; m2e = 0; m2l = 1;
    m4v = 0; m4d = 0; m4c = 0; m4e = 0; m4l = 3;
  endtask

  task automatic mupdate();
    logic [31:0] g;
    int k;
    g = grant_of(2, 32'(v2), m2l, f2, 32'(sel2));
    if (!m2v || ri2) begin
      m2v = |g;
      if (|g) begin
        k = idx_of(g);
        m2d = d2[k*32 +: 32]; m2c = k; m2l = k;
      end
    end
    if (f2 && $countones(sel2) != 1) m2e = 1;
    g = grant_of(4, 32'(v4), m4l, f4, 32'(sel4));
    if (!m4v || ri4) begin
      m4v = |g;
      if (|g) begin
        k = idx_of(g);
        m4d = d4[k*8 +: 8]; m4c = k; m4l = k;
      end
    end
    if (f4 && $countones(sel4) != 1) m4e = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) mupdate();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    v2 = 2'b11; ri2 = 1; f2 = 0; sel2 = 0;
    d2 = {32'h0000_5555, 32'hAAAA_0000};
    v4 = 0; ri4 = 1; f4 = 0; sel4 = 0; d4 = 0;
    #1;
    checks++;
    if (rdy2 !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready got=%b want=00", rdy2);
    end
    checks++;
    if ({vo2, do2, ch2, err2} !== '0) begin
      errors++;
      $display("FAIL rst_outs v=%b d=%h c=%0d e=%b want 0",
               vo2, do2, ch2, err2);
    end
    mreset();
    cyc(); cyc();
    rst_n = 1;
  endtask

  task automatic test_alternate();
    logic [1:0]  er;
    logic [31:0] ed;
    v2 = 2'b11; ri2 = 1;
    d2 = {32'h0000_5555, 32'hAAAA_0000};
    for (int i = 0; i < 6; i++) begin
      #1;
      er = (i % 2) ? 2'b10 : 2'b01;
      checks++;
      if (rdy2 !== er || rdy2 !== exp_rdy2()) begin
        errors++;
        $display("FAIL alt_ready[%0d] got=%b want=%b",
                 i, rdy2, er);
      end
      if (i > 0) begin
        ed = (i % 2) ? 32'hAAAA_0000 : 32'h0000_5555;
        checks++;
        if (!vo2 || do2 !== ed
            || ch2 !== 1'((i + 1) % 2)) begin
          errors++;
          $display("FAIL alt_data[%0d] got=%b/%h/%0d want=1/%h/%0d",
                   i, vo2, do2, ch2, ed, (i + 1) % 2);
        end
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    logic [31:0] hd;
    logic [0:0]  hc;
    hd = do2; hc = ch2;
    v2 = 2'b11; ri2 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdy2 !== 2'b00) begin
        errors++;
        $display("FAIL stall_ready[%0d] got=%b want=00",
                 i, rdy2);
      end
      checks++;
      if (!vo2 || do2 !== hd || ch2 !== hc
          || do2 !== m2d) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=%h/%0d want=%h/%0d",
                 i, do2, ch2, hd, hc);
      end
      cyc();
    end
    ri2 = 1;
    #1;
    checks++;
    if (rdy2 !== 2'b01 || rdy2 !== exp_rdy2()) begin
      errors++;
      $display("FAIL stall_release got=%b want=01", rdy2);
    end
    cyc();
  endtask

  task automatic test_force();
    f2 = 1; sel2 = 2'b10; v2 = 2'b11; ri2 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (rdy2 !== 2'b10) begin
        errors++;
        $display("FAIL force_ready[%0d] got=%b want=10",
                 i, rdy2);
      end
      cyc();
    end
    f2 = 0; sel2 = 0;
    #1;
    checks++;
    if (rdy2 !== 2'b01) begin
      errors++;
      $display("FAIL force_after got=%b want=01", rdy2);
    end
    checks++;
    if (do2 !== 32'h0000_5555 || ch2 !== 1'b1) begin
      errors++;
      $display("FAIL force_data got=%h/%0d want=00005555/1",
               do2, ch2);
    end
    cyc();
  endtask

  task automatic test_force_err();
    f2 = 1; sel2 = 2'b11; v2 = 2'b11; ri2 = 1;
    #1;
    checks++;
    if (rdy2 !== 2'b00 || err2 !== 1'b0) begin
      errors++;
      $display("FAIL err_pre got=%b/%b want=00/0", rdy2, err2);
    end
    cyc();
    sel2 = 2'b01;
    #1;
    checks++;
    if (err2 !== 1'b1 || rdy2 !== 2'b01) begin
      errors++;
      $display("FAIL err_set got=%b/%b want=1/01", err2, rdy2);
    end
    cyc();
    f2 = 0; sel2 = 0;
    #1;
    checks++;
    if (err2 !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b want=1", err2);
    end
    rst_n = 0;
    #1;
    checks++;
    if (err2 !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got=%b want=0", err2);
    end
    mreset();
    cyc();
    rst_n = 1;
  endtask

  task automatic test_els4();
    logic [3:0] seq [3];
    logic [7:0] dv  [3];
    seq = '{4'b1000, 4'b0010, 4'b1000};
    dv  = '{8'h44, 8'h22, 8'h44};
    v2 = 0; ri2 = 1;
    d4 = {8'h44, 8'h33, 8'h22, 8'h11};
    v4 = 4'b0010; ri4 = 1;
    #1;
    checks++;
    if (rdy4 !== 4'b0010) begin
      errors++;
      $display("FAIL e4_prime got=%b want=0010", rdy4);
    end
    cyc();
    v4 = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rdy4 !== seq[i] || rdy4 !== exp_rdy4()) begin
        errors++;
        $display("FAIL e4_grant[%0d] got=%b want=%b",
                 i, rdy4, seq[i]);
      end
      cyc();
      #1;
      checks++;
      if (!vo4 || do4 !== dv[i]
          || ch4 !== 2'(idx_of(32'(seq[i])))) begin
        errors++;
        $display("FAIL e4_data[%0d] got=%b/%h/%0d want=1/%h",
                 i, vo4, do4, ch4, dv[i]);
      end
    end
    v4 = 0;
    cyc();
    #1;
    checks++;
    if (vo4 !== 1'b0 || rdy4 !== 4'b0000) begin
      errors++;
      $display("FAIL e4_idle got=%b/%b want=0/0000", vo4, rdy4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      v2 = 2'($urandom); ri2 = 1'($urandom);
      d2 = {$urandom, $urandom};
      f2 = ($urandom_range(0, 3) == 0);
      sel2 = 2'b01 << $urandom_range(0, 1);
      if ($urandom_range(0, 40) == 0) sel2 = 2'($urandom);
      v4 = 4'($urandom); ri4 = ($urandom_range(0, 3) != 0);
      d4 = $urandom;
      f4 = ($urandom_range(0, 3) == 0);
      sel4 = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 40) == 0) sel4 = 4'($urandom);
      #1;
      checks++;
      if (rdy2 !== exp_rdy2()) begin
        errors++;
        $display("FAIL rnd2_ready[%0d] got=%b want=%b",
                 i, rdy2, exp_rdy2());
      end
      checks++;
      if (vo2 !== m2v || do2 !== m2d
          || ch2 !== 1'(m2c) || err2 !== m2e) begin
        errors++;
        $display("FAIL rnd2_out[%0d] got=%b/%h/%0d/%b want=%b/%h/%0d/%b",
                 i, vo2, do2, ch2, err2, m2v, m2d, m2c, m2e);
      end
      checks++;
      if (rdy4 !== exp_rdy4()) begin
        errors++;
        $display("FAIL rnd4_ready[%0d] got=%b want=%b",
                 i, rdy4, exp_rdy4());
      end
      checks++;
      if (vo4 !== m4v || do4 !== m4d
          || ch4 !== 2'(m4c) || err4 !== m4e) begin
        errors++;
        $display("FAIL rnd4_out[%0d] got=%b/%h/%0d/%b want=%b/%h/%0d/%b",
                 i, vo4, do4, ch4, err4, m4v, m4d, m4c, m4e);
      end
      cyc();
    end
  endtask

  task automatic test_async_reset();
    f2 = 0; sel2 = 0; f4 = 0; sel4 = 0; v4 = 0;
    v2 = 2'b11; ri2 = 1;
    d2 = {32'h1234_5678, 32'h9ABC_DEF0};
    cyc();
    ri2 = 0;
    #3;
    checks++;
    if (vo2 !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got=%b want=1", vo2);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({vo2, do2, ch2, err2} !== '0 || rdy2 !== 2'b00) begin
      errors++;
      $display("FAIL arst_outs v=%b d=%h c=%0d e=%b r=%b want 0",
               vo2, do2, ch2, err2, rdy2);
    end
    mreset();
    @(negedge clk);
    rst_n = 1; ri2 = 1;
    #1;
    checks++;
    if (rdy2 !== 2'b01) begin
      errors++;
      $display("FAIL arst_first got=%b want=01", rdy2);
    end
    cyc();
    #1;
    checks++;
    if (!vo2 || do2 !== 32'h9ABC_DEF0 || ch2 !== 1'b0) begin
      errors++;
      $display("FAIL arst_load got=%b/%h/%0d want=1/9abcdef0/0",
               vo2, do2, ch2);
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_stall();
    test_force();
    test_force_err();
    test_els4();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_mux_one_hot_arb_buffered.md
Name: bsg_mux_one_hot_arb_buffered

Overview:
- Parametrised successor to the combinational one-hot mux: els_p input channels, each width_p bits wide, each with its own valid/ready handshake.
- Per cycle the block picks one channel: by round-robin arbitration, or by a caller-supplied one-hot select when force mode is on.
- The chosen word is masked, OR-reduced, and captured in a single output register stage with valid/ready.
- Sits between multiple producers and one consumer, e.g. request merge in front of a network link.

Parameters:
- width_p, 32, data bits per channel.
- els_p, 2, number of input channels; legal range 1..32.
- Package constant lg_els_lp = max(1, $clog2(els_p)), width of the round-robin pointer.

Ports:
- clk_i  in  1  rising-edge clock.
- reset_n_i  in  1  reset; asynchronous assert, active-low.
- v_i  in  els_p  per-channel valid.
- data_i  in  els_p*width_p  channel k occupies bits [k*width_p +: width_p].
- ready_o  out  els_p  per-channel accept; one-hot or zero.
- force_i  in  1  1 = use sel_one_hot_i instead of round-robin.
- sel_one_hot_i  in  els_p  forced select; must be one-hot when force_i=1.
- v_o  out  1  output register holds valid data.
- data_o  out  width_p  registered muxed data.
- ready_i  in  1  downstream accept.
- chan_o  out  lg_els_lp  binary index of the channel held in the output register.
- err_o  out  1  sticky: set when force_i=1 and popcount(sel_one_hot_i)!=1; cleared only by reset.

Behaviour:
- Reset (async, reset_n_i=0): v_o=0, data_o=0, chan_o=0, err_o=0, rr pointer last_r=els_p-1 (channel 0 has first priority). ready_o is combinational and is 0 while v_o=0 is not stalled; ready_o is never asserted during reset.
- load_en = ~v_o | ready_i. This is combinational; ready_i propagates to ready_o in the same cycle, giving full throughput of 1 word/cycle.
- Round-robin grant (force_i=0):
  - grant = first set bit of v_i searching from index last_r+1 upward, wrapping modulo els_p.
  - grant=0 if v_i=0.
- Forced grant (force_i=1):
  - If sel_one_hot_i is one-hot, grant = sel_one_hot_i & v_i.
  - If sel_one_hot_i is not one-hot, grant=0 and err_o is set at the next edge.
  - A valid one-hot select whose channel has v_i=0 gives grant=0 with no error.
- ready_o = grant & {els_p{load_en}}. A transfer on channel k occurs when v_i[k] & ready_o[k].
- On a clock edge with load_en=1:
  - v_o <= |grant.
  - If |grant: data_o <= OR over k of (data_i[k] & {width_p{grant[k]}}), chan_o <= index(grant).
  - If grant=0: data_o and chan_o hold.
- On a clock edge with load_en=0: v_o, data_o and chan_o hold (stall). Inputs are not accepted.
- last_r updates to index(grant) only on a transfer, in both modes, so forced traffic also rotates fairness. It holds otherwise.
- Simultaneous cases:
  - ready_i=1 with v_o=1 and a new grant in the same cycle gives back-to-back output; the old word leaves and the new word loads.
  - All channels valid under round-robin gives a strict rotation 0,1,..,els_p-1,0.
- els_p=1: grant = v_i under round-robin; the pointer is a constant 0; force mode still checks the one-hot select.
- Reset mid-transfer: the held word is discarded (v_o=0); upstream sees no ready, so nothing is lost on the input side.
- Latency is 1 cycle from input transfer to v_o.

Decomposition:
- Shared package holds lg_els_lp, a popcount-is-one function, and a one-hot-to-binary function.
- One natural sub-module: bsg_arb_round_robin_one_hot. Inputs: v_i, last_r. Output: one-hot grant, combinational only. It is reusable by other merge blocks.
- The masking and OR-reduction stay inline in the top module.

Test Plan:
- Reset, then v_i=2'b11, data ch0=0xAAAA_0000, ch1=0x0000_5555, ready_i=1.
  - ready_o order: 01, 10, 01, ...
  - data_o one cycle later alternates 0xAAAA_0000 / 0x0000_5555, with chan_o 0/1.
- v_o=1 held, ready_i=0 for 3 cycles with v_i=11.
  - ready_o=00 for those cycles; data_o and chan_o stable.
  - First cycle with ready_i=1: ready_o grants the next round-robin channel.
- force_i=1, sel_one_hot_i=10, v_i=11 for 4 cycles.
  - ch1 granted every cycle.
  - After force_i drops, the next round-robin grant is ch0.
- force_i=1, sel_one_hot_i=11, v_i=11.
  - ready_o=00 and err_o=1 from the next edge.
  - err_o stays 1 after sel is corrected; reset clears it.
- els_p=4, width_p=8, v_i=4'b1010 with the pointer at 1.
  - Grant ch3, then ch1, then ch3.
  - v_i=0 gives v_o=0 on the next edge while ready_i=1.
- Assert reset_n_i asynchronously mid-cycle with v_o=1.
  - v_o, data_o, chan_o and err_o read 0 immediately, before the next edge.
  - After release, first grant goes to ch0.
